// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - pipelined instruction prefetch queue with redirect and stale-response drop
module inst_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] inst_address,
    output logic        inst_read_enable,
    input  logic        inst_wait_req,
    input  logic        inst_valid,
    input  logic [31:0] inst_data,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [CW:0] MAX_OS  = (CW + 1)'(MAX_OUTSTANDING);
    localparam logic [FW:0] DEPTH_W = (FW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [FW-1:0] count;
    logic [CW-1:0] live;
    logic [CW-1:0] stale;

    logic [31:0] mem_inst [DEPTH];
    logic [31:0] mem_pc   [DEPTH];

    logic [CW:0] os_sum;
    logic [FW:0] credit_sum;
    logic [31:0] redirect_aligned;
    logic        accepted;
    logic        resp;
    logic        drop;
    logic        wr;
    logic        pop;

    // Credits are computed one bit wider so the comparisons cannot wrap.
    assign os_sum     = {1'b0, live} + {1'b0, stale};
    assign credit_sum = {1'b0, count} + {{(FW + 1 - CW){1'b0}}, live};

    // Request only when both the outstanding limit and the FIFO slot reservation allow it.
    assign inst_read_enable = !reset && (os_sum < MAX_OS) && (credit_sum < DEPTH_W);
    assign inst_address     = fetch_pc;

    assign redirect_aligned = redirect_pc & ~32'h3;

    assign accepted = inst_read_enable && !inst_wait_req;
    assign resp     = inst_valid && ((live != '0) || (stale != '0));
    assign drop     = resp && (stale != '0);
    assign wr       = resp && (stale == '0);

    assign out_valid = !reset && (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_inst  = mem_inst[rd_ptr];
    assign out_pc    = mem_pc[rd_ptr];

    // Control state: PCs, FIFO pointers and the live/stale in-flight bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            live     <= '0;
            stale    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_aligned;
            resp_pc  <= redirect_aligned;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            live     <= '0;
            // Everything still owed by the bus, including a request taken this cycle, becomes stale.
            stale    <= stale + live + CW'(accepted) - CW'(resp);
        end else begin
            if (accepted) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (wr) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + FW'(wr) - FW'(pop);
            live  <= live + CW'(accepted) - CW'(wr);
            stale <= stale - CW'(drop);
        end
    end

    // FIFO storage; writes are suppressed while a redirect or reset discards them.
    always_ff @(posedge clock) begin
        if (wr && !redirect && !reset) begin
            mem_inst[wr_ptr] <= inst_data;
            mem_pc[wr_ptr]   <= resp_pc;
        end
    end

    // A response with nothing in flight means the bus broke protocol.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(inst_valid && (live == '0) && (stale == '0)));
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - scoreboard bench for inst_prefetch_queue with a randomized bus model
module tb_inst_prefetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clock;
    logic        reset;
    logic [31:0] inst_address;
    logic        inst_read_enable;
    logic        inst_wait_req;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    inst_prefetch_queue #(
        .DEPTH          (4),
        .MAX_OUTSTANDING(2),
        .RESET_PC       (RESET_PC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .inst_address    (inst_address),
        .inst_read_enable(inst_read_enable),
        .inst_wait_req   (inst_wait_req),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .out_valid       (out_valid),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_ready       (out_ready),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          acc_count = 0;
    int          first_acc_cyc = -1;
    int          first_valid_cyc = -1;
    int          pops = 0;
    logic [31:0] bus_exp_addr = RESET_PC;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] last_popped = 32'h1;
    logic [31:0] first_after = 32'hDEAD_BEEF;
    logic        awaiting_first = 1'b0;
    logic        prev_redir = 1'b0;
    logic        triple_seen = 1'b0;
    logic        saw_wrap = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_F00D;
    endfunction

    task automatic check(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // Bus model: in-order responses after a random latency; checks the address sequence.
    initial begin
        inst_valid = 1'b0;
        inst_data  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pend.delete();
                inst_valid    = 1'b0;
                acc_count     = 0;
                first_acc_cyc = -1;
                bus_exp_addr  = RESET_PC;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    inst_valid = 1'b1;
                    inst_data  = mem_word(pend[0].addr);
                    void'(pend.pop_front());
                end else begin
                    inst_valid = 1'b0;
                    inst_data  = $urandom;
                end
                if (inst_read_enable && !inst_wait_req) begin
                    req_t r;
                    check(inst_address == bus_exp_addr, "bus_addr", inst_address, bus_exp_addr);
                    r.addr = inst_address;
                    r.due  = cyc + $urandom_range(lat_min, lat_max);
                    pend.push_back(r);
                    acc_count++;
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    bus_exp_addr = bus_exp_addr + 32'd4;
                    if (redirect && inst_valid) triple_seen = 1'b1;
                end
                if (redirect) bus_exp_addr = redirect_pc & ~32'h3;
            end
        end
    end

    // Monitor: every consumed instruction must be the next PC of the current stream with its word.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                check(!inst_read_enable && !out_valid, "reset_outputs", {30'd0, inst_read_enable, out_valid}, 32'd0);
                exp_pc          = RESET_PC;
                first_valid_cyc = -1;
                prev_redir      = 1'b0;
                last_popped     = 32'h1;
            end else begin
                if (prev_redir) check(!out_valid, "post_redirect_empty", {31'd0, out_valid}, 32'd0);
                if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (redirect) begin
                    exp_pc         = redirect_pc & ~32'h3;
                    awaiting_first = 1'b1;
                    first_after    = 32'hDEAD_BEEF;
                    last_popped    = 32'h1;
                end else if (out_valid && out_ready) begin
                    check(out_pc == exp_pc, "out_pc", out_pc, exp_pc);
                    check(out_inst == mem_word(exp_pc), "out_inst", out_inst, mem_word(exp_pc));
                    if (awaiting_first) begin
                        first_after    = out_pc;
                        awaiting_first = 1'b0;
                    end
                    if (out_pc == 32'h0 && last_popped == 32'hFFFF_FFFC) saw_wrap = 1'b1;
                    last_popped = out_pc;
                    exp_pc      = exp_pc + 32'd4;
                    pops++;
                end
                prev_redir = redirect;
            end
        end
    end

    initial begin
        int          p0;
        int          waited;
        logic [31:0] addr0;
        reset         = 1'b1;
        inst_wait_req = 1'b0;
        out_ready     = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = '0;
        tick(3);

        // Streaming with a zero-wait, one-cycle bus.
        reset = 1'b0;
        tick(30);
        check(first_valid_cyc - first_acc_cyc == 2, "first_latency", 32'(first_valid_cyc - first_acc_cyc), 32'd2);
        p0 = pops;
        tick(20);
        check(pops - p0 == 20, "throughput", 32'(pops - p0), 32'd20);

        // Back-pressure fills the FIFO credit exactly.
        reset     = 1'b1;
        out_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(15);
        check(acc_count == 4, "full_accepts", 32'(acc_count), 32'd4);
        check(!inst_read_enable, "full_rd_en", {31'd0, inst_read_enable}, 32'd0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(10);
        check(acc_count == 5, "one_pop_one_req", 32'(acc_count), 32'd5);
        check(!inst_read_enable, "refull_rd_en", {31'd0, inst_read_enable}, 32'd0);

        // Redirect with two reads in flight.
        out_ready = 1'b1;
        lat_min   = 3;
        lat_max   = 3;
        waited    = 0;
        while (pend.size() != 2 && waited < 20) begin
            tick(1);
            waited++;
        end
        check(pend.size() == 2, "two_in_flight", 32'(pend.size()), 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1002;
        tick(1);
        redirect = 1'b0;
        tick(25);
        check(first_after == 32'h0000_1000, "redirect_target", first_after, 32'h0000_1000);

        // Redirect coinciding with an accepted request and a response.
        lat_min = 1;
        lat_max = 1;
        tick(10);
        triple_seen = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2000;
        tick(1);
        redirect = 1'b0;
        check(triple_seen, "same_cycle_events", {31'd0, triple_seen}, 32'd1);
        tick(20);
        check(first_after == 32'h0000_2000, "same_cycle_target", first_after, 32'h0000_2000);

        // Bus stall holds the request steady.
        lat_max       = 3;
        inst_wait_req = 1'b1;
        tick(6);
        addr0 = inst_address;
        for (int i = 0; i < 10; i++) begin
            check(inst_read_enable && inst_address == addr0, "stall_stable", inst_address, addr0);
            tick(1);
        end
        inst_wait_req = 1'b0;
        tick(20);

        // Address wrap at the top of the space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        tick(20);
        check(saw_wrap, "pc_wrap", {31'd0, saw_wrap}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            out_ready     = ($urandom_range(0, 3) != 0);
            inst_wait_req = ($urandom_range(0, 3) == 0);
            redirect      = ($urandom_range(0, 24) == 0);
            redirect_pc   = $urandom;
            tick(1);
        end
        redirect      = 1'b0;
        inst_wait_req = 1'b0;
        out_ready     = 1'b1;
        p0            = pops;
        tick(20);
        check(pops - p0 >= 10, "random_drain", 32'(pops - p0), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
